// File: rtl/btn_step_generator.sv
// Turns raw left/right buttons into clean one-cycle step pulses: sync, debounce, one pulse per press.
// Press-to-pulse latency SYNC_STAGES+DEBOUNCE_CYCLES+1 cycles; no backpressure; BTN_AUTO_REPEAT_EN adds hold-to-repeat.
module btn_step_generator #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 23000000
) (
  input  logic clk_100mhz,
  input  logic rst_n,
  input  logic btn_left,
  input  logic btn_right,
  output logic step_left,
  output logic step_right,
  output logic left_held,
  output logic right_held
);

  localparam int MAXA = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXP = (MAXA > REPEAT_PERIOD) ? MAXA : REPEAT_PERIOD;
  localparam int CW   = $clog2(MAXP + 1);

`ifdef BTN_AUTO_REPEAT_EN
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_REPEAT, S_LOCK} state_t;
`else
  typedef enum logic {S_IDLE, S_LOCK} state_t;
`endif

  state_t state_q, state_d;

  // Bit 0 is the left button, bit 1 the right button throughout.
  logic [SYNC_STAGES-1:0] sync_l_q, sync_r_q;
  logic [1:0]             sync_v;
  logic [1:0]             db_q, db_d;
  logic [1:0]             held_q;
  logic [1:0]             rise;
  logic [1:0]             step_q, step_d;
  logic [CW-1:0]          dbc_q [2];
  logic [CW-1:0]          dbc_d [2];

`ifdef BTN_AUTO_REPEAT_EN
  logic          dir_q, dir_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] rlim;
`endif

  assign sync_v = {sync_r_q[SYNC_STAGES-1], sync_l_q[SYNC_STAGES-1]};
  // held_q is the debounced level one cycle late, so it doubles as the edge reference.
  assign rise   = db_q & ~held_q;

  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 2; i++) begin
      dbc_d[i] = '0;
      if (sync_v[i] != db_q[i]) begin
        if (dbc_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_d[i] = sync_v[i];
        end else begin
          dbc_d[i] = dbc_q[i] + 1'b1;
        end
      end
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  assign rlim = (state_q == S_DELAY) ? CW'(REPEAT_DELAY - 1) : CW'(REPEAT_PERIOD - 1);
`endif

  always_comb begin
    state_d = state_q;
    step_d  = 2'b00;
`ifdef BTN_AUTO_REPEAT_EN
    dir_d   = dir_q;
    rcnt_d  = rcnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        // A rise while the other button is already down is a conflict, not a step.
        if ((rise[0] && db_q[1]) || (rise[1] && db_q[0])) begin
          state_d = S_LOCK;
        end else if (rise != 2'b00) begin
          step_d = rise;
`ifdef BTN_AUTO_REPEAT_EN
          dir_d   = rise[1];
          rcnt_d  = '0;
          state_d = S_DELAY;
`else
          state_d = S_LOCK;
`endif
        end
      end
`ifdef BTN_AUTO_REPEAT_EN
      S_DELAY, S_REPEAT: begin
        if (!db_q[dir_q]) begin
          state_d = S_IDLE;
          rcnt_d  = '0;
        end else if (rise[~dir_q]) begin
          state_d = S_LOCK;
          rcnt_d  = '0;
        end else if (rcnt_q == rlim) begin
          step_d[dir_q] = 1'b1;
          rcnt_d        = '0;
          state_d       = S_REPEAT;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
`endif
      S_LOCK: begin
        if (db_q == 2'b00) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (!rst_n) begin
      sync_l_q <= '0;
      sync_r_q <= '0;
      db_q     <= '0;
      held_q   <= '0;
      step_q   <= '0;
      dbc_q[0] <= '0;
      dbc_q[1] <= '0;
      state_q  <= S_IDLE;
`ifdef BTN_AUTO_REPEAT_EN
      dir_q    <= 1'b0;
      rcnt_q   <= '0;
`endif
    end else begin
      sync_l_q <= {sync_l_q[SYNC_STAGES-2:0], btn_left};
      sync_r_q <= {sync_r_q[SYNC_STAGES-2:0], btn_right};
      db_q     <= db_d;
      held_q   <= db_q;
      step_q   <= step_d;
      dbc_q[0] <= dbc_d[0];
      dbc_q[1] <= dbc_d[1];
      state_q  <= state_d;
`ifdef BTN_AUTO_REPEAT_EN
      dir_q    <= dir_d;
      rcnt_q   <= rcnt_d;
`endif
    end
  end

  assign step_left  = step_q[0];
  assign step_right = step_q[1];
  assign left_held  = held_q[0];
  assign right_held = held_q[1];

endmodule

// File: tb/tb_btn_step_generator.sv
// Randomised and directed bench for btn_step_generator against a timestamp-based reference model.
module tb_btn_step_generator;

  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int REPEAT_DELAY    = 20;
  localparam int REPEAT_PERIOD   = 8;

  logic clk_100mhz = 1'b0;
  logic rst_n      = 1'b0;
  logic btn_left   = 1'b0;
  logic btn_right  = 1'b0;
  logic step_left, step_right, left_held, right_held;

  int n_checks = 0;
  int n_fails  = 0;
  int n_sl     = 0;
  int n_sr     = 0;

  btn_step_generator #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst_n     (rst_n),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .step_left (step_left),
    .step_right(step_right),
    .left_held (left_held),
    .right_held(right_held)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fails++;
      $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: raw delay line, run-length debounce, and press timestamps for pulse scheduling.
  logic [SYNC_STAGES-1:0] m_sl = '0, m_sr = '0;
  bit m_db_l = 0, m_db_r = 0, m_h_l = 0, m_h_r = 0, m_st_l = 0, m_st_r = 0;
  int m_run_l = 0, m_run_r = 0;
  int m_mode = 0;   // 0 waiting for a press, 1 press owned by m_dir, 2 locked out
  bit m_dir = 0;    // 0 left, 1 right
  int m_edge = 0, m_t0 = 0;

  task automatic model_edge();
    bit rl, rr, pl, pr, sl, sr;
    int age;
    if (!rst_n) begin
      m_sl = '0; m_sr = '0;
      m_db_l = 0; m_db_r = 0; m_h_l = 0; m_h_r = 0;
      m_st_l = 0; m_st_r = 0; m_run_l = 0; m_run_r = 0;
      m_mode = 0; m_dir = 0; m_edge = 0; m_t0 = 0;
      return;
    end
    m_edge++;
    rl = m_db_l && !m_h_l;
    rr = m_db_r && !m_h_r;
    pl = 0;
    pr = 0;
    case (m_mode)
      0: begin
        if ((rl && m_db_r) || (rr && m_db_l)) m_mode = 2;
        else if (rl || rr) begin
          pl = rl; pr = rr; m_dir = rr; m_t0 = m_edge;
`ifdef BTN_AUTO_REPEAT_EN
          m_mode = 1;
`else
          m_mode = 2;
`endif
        end
      end
      1: begin
        age = m_edge - m_t0;
        if (!(m_dir ? m_db_r : m_db_l)) m_mode = 0;
        else if (m_dir ? rl : rr) m_mode = 2;
        else if (age >= REPEAT_DELAY && ((age - REPEAT_DELAY) % REPEAT_PERIOD) == 0) begin
          pl = !m_dir; pr = m_dir;
        end
      end
      default: if (!m_db_l && !m_db_r) m_mode = 0;
    endcase
    m_h_l = m_db_l;
    m_h_r = m_db_r;
    sl = m_sl[SYNC_STAGES-1];
    sr = m_sr[SYNC_STAGES-1];
    m_sl = {m_sl[SYNC_STAGES-2:0], btn_left};
    m_sr = {m_sr[SYNC_STAGES-2:0], btn_right};
    if (sl != m_db_l) begin
      m_run_l++;
      if (m_run_l == DEBOUNCE_CYCLES) begin m_db_l = sl; m_run_l = 0; end
    end else m_run_l = 0;
    if (sr != m_db_r) begin
      m_run_r++;
      if (m_run_r == DEBOUNCE_CYCLES) begin m_db_r = sr; m_run_r = 0; end
    end else m_run_r = 0;
    m_st_l = pl;
    m_st_r = pr;
  endtask

  task automatic tick();
    @(posedge clk_100mhz);
    model_edge();
    #1;
    chk("step_left",  int'(step_left),  int'(m_st_l));
    chk("step_right", int'(step_right), int'(m_st_r));
    chk("left_held",  int'(left_held),  int'(m_h_l));
    chk("right_held", int'(right_held), int'(m_h_r));
    n_sl += int'(step_left);
    n_sr += int'(step_right);
  endtask

  initial begin
    int first, fall, any_held, sl0, sr0;
    int exp_q[$];
    int got_q[$];

    // Reset with the left button already down.
    rst_n = 1'b0; btn_left = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", int'({step_left, step_right, left_held, right_held}), 0);
    rst_n = 1'b1;
    first = -1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (step_left && first < 0) first = i;
    end
    chk("reset_first_step", first, 7);
    btn_left = 1'b0;
    repeat (20) tick();

    // Short right-button glitches must be filtered out.
    sr0 = n_sr; any_held = 0;
    repeat (5) begin
      btn_right = 1'b1;
      repeat (3) begin tick(); any_held |= int'(right_held); end
      btn_right = 1'b0;
      repeat (2) begin tick(); any_held |= int'(right_held); end
    end
    repeat (10) begin tick(); any_held |= int'(right_held); end
    chk("glitch_steps", n_sr - sr0, 0);
    chk("glitch_held", any_held, 0);

    // Long left hold: one pulse, or the repeat train when auto-repeat is built in.
    got_q.delete(); fall = -1;
    btn_left = 1'b1;
    for (int i = 1; i <= 90; i++) begin
      if (i == 61) btn_left = 1'b0;
      tick();
      if (step_left) got_q.push_back(i);
      if (i > 7 && !left_held && fall < 0) fall = i;
    end
`ifdef BTN_AUTO_REPEAT_EN
    exp_q = '{7, 27, 35, 43, 51, 59};
`else
    exp_q = '{7};
`endif
    chk("hold_pulse_count", got_q.size(), exp_q.size());
    foreach (exp_q[k]) chk("hold_pulse_cycle", (k < got_q.size()) ? got_q[k] : -1, exp_q[k]);
    chk("hold_release_fall", fall, 67);

    // Both buttons together: locked out until both released.
    sl0 = n_sl; sr0 = n_sr;
    btn_left = 1'b1; btn_right = 1'b1;
    repeat (40) tick();
    btn_left = 1'b0; btn_right = 1'b0;
    repeat (20) tick();
    chk("simul_steps", (n_sl - sl0) + (n_sr - sr0), 0);
    btn_right = 1'b1; first = -1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (step_right && first < 0) first = i;
    end
    chk("simul_fresh_right", first, 7);
    btn_right = 1'b0;
    repeat (20) tick();

    // Conflict: right joins a left press, then left lets go first.
    sl0 = n_sl; sr0 = n_sr; first = -1;
    btn_left = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      if (first < 0) begin
        tick();
        if (step_left) first = i;
      end
    end
    chk("conflict_first_left", first, 7);
    repeat (10) tick();
    btn_right = 1'b1;
    repeat (15) tick();
    btn_left = 1'b0;
    repeat (30) tick();
    chk("conflict_left_steps", n_sl - sl0, 1);
    chk("conflict_right_steps", n_sr - sr0, 0);
    btn_right = 1'b0;
    repeat (20) tick();
    btn_left = 1'b1; first = -1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (step_left && first < 0) first = i;
    end
    chk("conflict_resume", first, 7);
    btn_left = 1'b0;
    repeat (20) tick();

    // Random button activity with occasional resets.
    for (int seg = 0; seg < 300; seg++) begin
      btn_left  = 1'($urandom_range(0, 1));
      btn_right = 1'($urandom_range(0, 1));
      rst_n     = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
      repeat ($urandom_range(1, 40)) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/btn_step_generator.md
Name: btn_step_generator

Overview:
- Front end for the LED-movement logic: conditions the raw left/right push-buttons into clean single-cycle step requests.
- Synchronises each button, debounces it, and issues one step pulse per press.
- With the optional feature compiled in, a held button also produces auto-repeat pulses at a fixed rate.
- Downstream logic moves the one-hot LED exactly once per pulse, so it needs no delay counter of its own.

Parameters:
- SYNC_STAGES, 2: synchroniser flop depth per button (>=2).
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed before a debounced level changes (10 ms at 100 MHz).
- REPEAT_DELAY, 50000000: cycles from the first pulse to the first auto-repeat pulse (500 ms).
- REPEAT_PERIOD, 23000000: cycles between successive auto-repeat pulses (230 ms).

Ports:
- clk_100mhz  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk_100mhz.
- btn_left  input  1  raw asynchronous left button, active high.
- btn_right  input  1  raw asynchronous right button, active high.
- step_left  output  1  one-cycle pulse: move the LED one position left.
- step_right  output  1  one-cycle pulse: move the LED one position right.
- left_held  output  1  debounced level of the left button.
- right_held  output  1  debounced level of the right button.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Synchroniser flops, debounced levels, all counters, step_left, step_right, left_held and right_held go to 0.
  - FSM goes to IDLE.
  - Reset mid-press or mid-repeat discards all history. A button still held after release of reset must re-qualify through the full debounce before it can produce a pulse.
- Synchroniser: SYNC_STAGES-flop chain per button.
- Debounce, per button:
  - A counter increments while the synchronised value differs from the debounced level.
  - The counter clears whenever the two are equal.
  - When the count reaches DEBOUNCE_CYCLES, the debounced level takes the new value and the counter clears.
  - Glitches shorter than DEBOUNCE_CYCLES never change the debounced level.
- left_held and right_held are the debounced levels, registered.
- FSM states: IDLE, DELAY, REPEAT, LOCK. A register dir (L/R) records the active button.
  - IDLE, left debounced rises with right low: step pulse for left in the next cycle, dir=L, counter=0, go DELAY. Right is symmetric.
  - IDLE, both debounced levels rise in the same cycle: no pulse, go LOCK.
  - DELAY: counter increments each cycle.
    - Active button's debounced level falls: go IDLE, no pulse.
    - Else the other button's debounced level rises: go LOCK, no pulse.
    - Else counter == REPEAT_DELAY-1: pulse for dir, counter=0, go REPEAT.
  - REPEAT: same release and conflict rules. counter == REPEAT_PERIOD-1 gives a pulse for dir and counter=0; stay in REPEAT.
  - LOCK: no pulses. Go IDLE when both debounced levels are 0.
- Latency: a clean raw press held from cycle 0 gives its first step pulse high exactly in cycle SYNC_STAGES+DEBOUNCE_CYCLES+1.
- Auto-repeat spacing:
  - First repeat pulse comes REPEAT_DELAY cycles after the first pulse.
  - Later repeat pulses are REPEAT_PERIOD cycles apart.
- step_left and step_right are registered. They are never high together and never high for two consecutive cycles. Each pulse is exactly one cycle wide.
- Release: a button released while the other is still held does not start a step for the remaining button. The FSM stays in LOCK until both buttons are released.
- Counters are sized with $clog2 of the largest parameter and never wrap. Each counter clears at its terminal count.

Optional Feature:
- Macro: BTN_AUTO_REPEAT_EN.
- Defined: DELAY and REPEAT behave as specified above.
- Undefined: DELAY and REPEAT do not exist. After the press pulse the FSM waits in LOCK until both buttons are released. Exactly one pulse per press. REPEAT_DELAY and REPEAT_PERIOD are unused. Release and conflict handling is otherwise unchanged.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset behaviour:
  - Stimulus: hold rst_n=0 for 3 cycles with btn_left=1, then release reset.
  - Response: all outputs 0 during reset; first step_left exactly 7 cycles after rst_n rises.
- Debounce:
  - Stimulus: btn_right pulsed high for 3 cycles, low for 2, repeated 5 times.
  - Response: right_held stays 0 and no step_right pulse occurs.
- Auto-repeat (macro defined):
  - Stimulus: btn_left high from cycle 0 to 60.
  - Response: step_left in cycles 7, 27, 35, 43, 51, 59. left_held falls 7 cycles after release, with no further pulses.
- Single pulse (macro undefined):
  - Stimulus: same as the auto-repeat test.
  - Response: a single step_left at cycle 7 only.
- Simultaneous press:
  - Stimulus: btn_left and btn_right both rise in cycle 0 and stay high for 40 cycles.
  - Response: no step pulses. After both are released, a fresh btn_right press produces step_right at 7 cycles.
- Conflict and release:
  - Stimulus: btn_left pressed, then btn_right pressed 10 cycles after step_left, then btn_left released.
  - Response: one step_left only, no step_right. Step pulses resume only after both buttons are released and a new press arrives.
